game_logic_nxn: RTL and testbench

- Parametrised successor of the fixed 4x4 2048 game engine.
- Holds an N x N grid of TILE_W-bit exponent tiles (0 = empty, v means tile 2^v) and executes moves from the four direction buttons.
- Processes one row per cycle, spawns new tiles from the LFSR, keeps a saturating score, and detects game over.
- Feeds the VGA renderer (grid, score, game_over) and accepts debug grid writes from the test interface.

---
 rtl/game_logic_nxn.sv | 262 ++++++++++++++++++++++++++
 tb/tb_game_logic_nxn.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_logic_nxn.sv
// game_logic_nxn: N x N 2048 engine, one row per cycle.
// Moves via transpose/mirror, LFSR spawn, saturating score, game-over check.
module game_logic_nxn #(
    parameter int N       = 4,
    parameter int TILE_W  = 4,
    parameter int SCORE_W = 16,
    parameter int LFSR_W  = 16,
    parameter int IDX_W   = $clog2(N*N)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     btn_up,
    input  logic                     btn_right,
    input  logic                     btn_down,
    input  logic                     btn_left,
    input  logic [LFSR_W-1:0]        lfsr_value,
    input  logic                     debug_grid_valid,
    input  logic [IDX_W-1:0]         debug_grid_addr,
    input  logic [TILE_W-1:0]        debug_grid_data,
    output logic [N*N*TILE_W-1:0]    grid,
    output logic [SCORE_W-1:0]       score,
    output logic                     game_over,
    output logic                     busy,
    output logic                     move_done,
    output logic                     move_valid
);

    localparam int CELLS = N*N;
    localparam int NCH   = LFSR_W / IDX_W;
    localparam int SH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RW    = $clog2(N);
    localparam logic [TILE_W-1:0]  MAXV = '1;
    localparam logic [SCORE_W:0]   SAT  = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [SCORE_W:0]   ONE  = {{SCORE_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE_START, IDLE, XPOSE_IN, ROWS,
        XPOSE_OUT, SPAWN, CHECK, OVER
    } state_t;

    typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_t;

    logic [TILE_W-1:0]            cells [CELLS];
    state_t                       state;
    dir_t                         dir, dir_n;
    logic                         prev_btn, any_btn, press;
    logic [SH_W-1:0]              lfsr_shift;
    logic [1:0]                   spawn_cnt;
    logic                         from_start;
    logic [RW-1:0]                row_idx;
    logic                         vert, rev;
    logic [IDX_W-1:0]             cand;
    logic                         cand_ok;
    logic [N-1:0][TILE_W-1:0]     row_raw, row_in, row_out, row_new;
    logic [N:0][TILE_W-1:0]       cmp;
    logic [SCORE_W:0]             gain, score_sum;
    logic [TILE_W-1:0]            nv;
    logic                         row_changed, skip, over_c;
    int                           base, j, k;

    assign any_btn = btn_up | btn_right | btn_down | btn_left;
    assign press   = any_btn & ~prev_btn;
    assign vert    = (dir == D_UP) || (dir == D_DOWN);
    assign rev     = (dir == D_RIGHT) || (dir == D_DOWN);
    assign cand    = lfsr_value[int'(lfsr_shift)*IDX_W +: IDX_W];
    assign cand_ok = (int'(cand) < CELLS) && (cells[cand] == '0);

    // Button priority: left, right, up, down.
    always_comb begin
        dir_n = D_DOWN;
        if (btn_left)       dir_n = D_LEFT;
        else if (btn_right) dir_n = D_RIGHT;
        else if (btn_up)    dir_n = D_UP;
    end

    // Push/merge of the current row toward its leading edge, with score gain.
    always_comb begin
        base = int'(row_idx) * N;
        row_raw = '0;
        row_in = '0;
        row_out = '0;
        row_new = '0;
        cmp = '0;
        gain = '0;
        nv = '0;
        skip = 1'b0;
        j = 0;
        k = 0;
        for (int c = 0; c < N; c++) row_raw[c] = cells[base + c];
        for (int c = 0; c < N; c++) row_in[c] = rev ? row_raw[N-1-c] : row_raw[c];
        for (int i = 0; i < N; i++) begin
            if (row_in[i] != '0) begin
                cmp[j] = row_in[i];
                j = j + 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (cmp[i] != '0) begin
                if (cmp[i] == cmp[i+1] && cmp[i] != MAXV) begin
                    nv = cmp[i] + 1'b1;
                    row_out[k] = nv;
                    skip = 1'b1;
                    if (int'(nv) >= SCORE_W) begin
                        gain = SAT;
                    end else begin
                        gain = gain + (ONE << nv);
                        if (gain[SCORE_W]) gain = SAT;
                    end
                end else begin
                    row_out[k] = cmp[i];
                end
                k = k + 1;
            end
        end
        for (int c = 0; c < N; c++) row_new[c] = rev ? row_out[N-1-c] : row_out[c];
        row_changed = (row_out != row_in);
        score_sum = {1'b0, score} + gain;
    end

    // Game over: no empty cell and no mergeable neighbour pair.
    always_comb begin
        over_c = 1'b1;
        for (int i = 0; i < CELLS; i++)
            if (cells[i] == '0) over_c = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N-1; c++)
                if (cells[r*N+c] == cells[r*N+c+1] && cells[r*N+c] != MAXV)
                    over_c = 1'b0;
        for (int r = 0; r < N-1; r++)
            for (int c = 0; c < N; c++)
                if (cells[r*N+c] == cells[(r+1)*N+c] && cells[r*N+c] != MAXV)
                    over_c = 1'b0;
    end

    // Flatten cells onto the output bus, cell 0 at the MSBs.
    always_comb begin
        grid = '0;
        for (int i = 0; i < CELLS; i++)
            grid[(CELLS-1-i)*TILE_W +: TILE_W] = cells[i];
    end

    // Main FSM; debug write applied last so it wins on its cell.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) cells[i] <= '0;
            state      <= IDLE_START;
            dir        <= D_LEFT;
            prev_btn   <= 1'b0;
            lfsr_shift <= '0;
            spawn_cnt  <= '0;
            from_start <= 1'b0;
            row_idx    <= '0;
            score      <= '0;
            game_over  <= 1'b0;
            busy       <= 1'b0;
            move_done  <= 1'b0;
            move_valid <= 1'b0;
        end else begin
            prev_btn   <= any_btn;
            lfsr_shift <= (lfsr_shift == '0) ? SH_W'(NCH-1) : lfsr_shift - 1'b1;
            move_done  <= 1'b0;
            unique case (state)
                IDLE_START: begin
                    if (press) begin
                        spawn_cnt  <= 2'd2;
                        from_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SPAWN;
                    end
                end
                IDLE: begin
                    if (press) begin
                        dir        <= dir_n;
                        move_valid <= 1'b0;
                        row_idx    <= '0;
                        busy       <= 1'b1;
                        if (dir_n == D_UP || dir_n == D_DOWN) state <= XPOSE_IN;
                        else state <= ROWS;
                    end
                end
                XPOSE_IN: begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            cells[r*N+c] <= cells[c*N+r];
                    state <= ROWS;
                end
                ROWS: begin
                    for (int c = 0; c < N; c++) cells[base + c] <= row_new[c];
                    if (row_changed) move_valid <= 1'b1;
                    score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    if (row_idx == RW'(N-1)) begin
                        if (vert) begin
                            state <= XPOSE_OUT;
                        end else if (move_valid || row_changed) begin
                            spawn_cnt  <= 2'd1;
                            from_start <= 1'b0;
                            state      <= SPAWN;
                        end else begin
                            move_done <= 1'b1;
                            state     <= CHECK;
                        end
                    end else begin
                        row_idx <= row_idx + 1'b1;
                    end
                end
                XPOSE_OUT: begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            cells[r*N+c] <= cells[c*N+r];
                    if (move_valid) begin
                        spawn_cnt  <= 2'd1;
                        from_start <= 1'b0;
                        state      <= SPAWN;
                    end else begin
                        move_done <= 1'b1;
                        state     <= CHECK;
                    end
                end
                SPAWN: begin
                    if (spawn_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cand_ok) begin
                        cells[cand] <= TILE_W'(1);
                        spawn_cnt   <= spawn_cnt - 1'b1;
                        if (spawn_cnt == 2'd1) begin
                            if (from_start) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                move_done <= 1'b1;
                                state     <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    game_over <= over_c;
                    busy      <= 1'b0;
                    state     <= over_c ? OVER : IDLE;
                end
                OVER: begin
                    if (press) begin
                        for (int i = 0; i < CELLS; i++) cells[i] <= '0;
                        score      <= '0;
                        game_over  <= 1'b0;
                        move_valid <= 1'b0;
                        spawn_cnt  <= 2'd2;
                        from_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SPAWN;
                    end
                end
            endcase
            if (debug_grid_valid && int'(debug_grid_addr) < CELLS)
                cells[debug_grid_addr] <= debug_grid_data;
        end
    end

endmodule

// File: tb/tb_game_logic_nxn.sv
// tb_game_logic_nxn: directed vectors for the 2048 engine.
// 4x4 instance for moves/score/game-over, 5x5 instance for spawn range and saturation.
module tb_game_logic_nxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         up4, rt4, dn4, lf4, dv4;
    logic [15:0]  lfsr4;
    logic [3:0]   da4, dd4;
    logic [63:0]  grid4;
    logic [15:0]  score4;
    logic         go4, busy4, md4, mv4;

    logic         up5, rt5, dn5, lf5, dv5;
    logic [15:0]  lfsr5;
    logic [4:0]   da5, dd5;
    logic [124:0] grid5;
    logic [15:0]  score5;
    logic         go5, busy5, md5, mv5;

    int vec = 0;
    int miss = 0;
    int cyc5 = 0;
    int n;
    logic saw;
    logic [124:0] e5;

    game_logic_nxn #(.N(4), .TILE_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .btn_up(up4), .btn_right(rt4), .btn_down(dn4), .btn_left(lf4),
        .lfsr_value(lfsr4),
        .debug_grid_valid(dv4), .debug_grid_addr(da4), .debug_grid_data(dd4),
        .grid(grid4), .score(score4), .game_over(go4),
        .busy(busy4), .move_done(md4), .move_valid(mv4)
    );

    game_logic_nxn #(.N(5), .TILE_W(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n),
        .btn_up(up5), .btn_right(rt5), .btn_down(dn5), .btn_left(lf5),
        .lfsr_value(lfsr5),
        .debug_grid_valid(dv5), .debug_grid_addr(da5), .debug_grid_data(dd5),
        .grid(grid5), .score(score5), .game_over(go5),
        .busy(busy5), .move_done(md5), .move_valid(mv5)
    );

    // 5x5 random source: only chunk 0 is ever a legal index (3 or 9).
    always @(negedge clk) begin
        cyc5 <= cyc5 + 1;
        lfsr5 = {1'b0, 5'd31, 5'd28, (cyc5[0] ? 5'd3 : 5'd9)};
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cnt4(input logic [63:0] g, input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) if (g[(15-i)*4 +: 4] == v) c++;
        return c;
    endfunction

    function automatic int cnt5(input logic [124:0] g, input logic [4:0] v);
        int c = 0;
        for (int i = 0; i < 25; i++) if (g[(24-i)*5 +: 5] == v) c++;
        return c;
    endfunction

    task automatic set4(input logic [63:0] g);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            dv4 = 1'b1;
            da4 = 4'(i);
            dd4 = g[(15-i)*4 +: 4];
        end
        @(negedge clk);
        dv4 = 1'b0;
    endtask

    task automatic set5(input logic [124:0] g);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            dv5 = 1'b1;
            da5 = 5'(i);
            dd5 = g[(24-i)*5 +: 5];
        end
        @(negedge clk);
        dv5 = 1'b0;
    endtask

    task automatic btn4(input int d);
        @(negedge clk);
        case (d)
            0: lf4 = 1'b1;
            1: rt4 = 1'b1;
            2: up4 = 1'b1;
            default: dn4 = 1'b1;
        endcase
        @(negedge clk);
        {lf4, rt4, up4, dn4} = '0;
    endtask

    task automatic btn5(input int d);
        @(negedge clk);
        if (d == 0) lf5 = 1'b1;
        else rt5 = 1'b1;
        @(negedge clk);
        {lf5, rt5, up5, dn5} = '0;
    endtask

    task automatic move4(input int d, output int cnt);
        btn4(d);
        cnt = 1;
        while (!md4 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic idle4(output int cnt, output logic s);
        cnt = 0;
        s = 1'b0;
        while (busy4 && cnt < 200) begin
            s = s | md4;
            @(negedge clk);
            cnt++;
        end
        s = s | md4;
    endtask

    task automatic idle5(output int cnt, output logic s);
        cnt = 0;
        s = 1'b0;
        while (busy5 && cnt < 200) begin
            s = s | md5;
            @(negedge clk);
            cnt++;
        end
        s = s | md5;
    endtask

    initial begin
        rst_n = 1'b0;
        {up4, rt4, dn4, lf4, dv4} = '0;
        {up5, rt5, dn5, lf5, dv5} = '0;
        lfsr4 = '0;
        da4 = '0; dd4 = '0; da5 = '0; dd5 = '0;
        repeat (3) @(negedge clk);
        chk("rst_grid", 128'(grid4), 128'(0));
        chk("rst_score", 128'(score4), 128'(0));
        chk("rst_flags", 128'({go4, busy4, md4, mv4}), 128'(0));
        rst_n = 1'b1;

        lfsr4 = 16'h4321;
        btn4(0);
        idle4(n, saw);
        chk("start_bounded", 128'(n < 200), 128'(1));
        chk("start_ones", 128'(cnt4(grid4, 4'd1)), 128'(2));
        chk("start_empty", 128'(cnt4(grid4, 4'd0)), 128'(14));
        chk("start_score", 128'(score4), 128'(0));
        chk("start_no_done", 128'(saw), 128'(0));

        lfsr4 = 16'h5555;
        set4(64'h1122_0000_0000_0000);
        move4(0, n);
        chk("left_latency", 128'(n), 128'(6));
        chk("left_grid", 128'(grid4), 128'(64'h2300_0100_0000_0000));
        chk("left_score", 128'(score4), 128'(12));
        chk("left_valid", 128'(mv4), 128'(1));
        @(negedge clk);
        chk("left_idle", 128'({busy4, md4, go4}), 128'(0));

        set4(64'h1110_0000_0000_0000);
        move4(1, n);
        chk("right_latency", 128'(n), 128'(6));
        chk("right_grid", 128'(grid4), 128'(64'h0012_0100_0000_0000));
        chk("right_score", 128'(score4), 128'(16));
        @(negedge clk);

        set4(64'h1000_0000_1002_2002);
        move4(2, n);
        chk("up_latency", 128'(n), 128'(8));
        chk("up_grid", 128'(grid4), 128'(64'h2003_2100_0000_0000));
        chk("up_score", 128'(score4), 128'(28));
        @(negedge clk);

        set4(64'h0200_0000_0200_0100);
        move4(3, n);
        chk("down_latency", 128'(n), 128'(8));
        chk("down_grid", 128'(grid4), 128'(64'h0000_0100_0300_0100));
        chk("down_score", 128'(score4), 128'(36));
        @(negedge clk);

        set4(64'hFF00_0000_0000_0000);
        move4(0, n);
        chk("maxv_latency", 128'(n), 128'(5));
        chk("maxv_grid", 128'(grid4), 128'(64'hFF00_0000_0000_0000));
        chk("maxv_valid", 128'(mv4), 128'(0));
        chk("maxv_score", 128'(score4), 128'(36));
        @(negedge clk);
        chk("maxv_not_over", 128'({go4, busy4}), 128'(0));

        set4(64'h1212_2121_1212_2121);
        move4(0, n);
        chk("over_latency", 128'(n), 128'(5));
        @(negedge clk);
        chk("over_flag", 128'(go4), 128'(1));
        chk("over_valid", 128'(mv4), 128'(0));
        repeat (3) @(negedge clk);
        chk("over_frozen", 128'(grid4), 128'(64'h1212_2121_1212_2121));
        lfsr4 = 16'h4321;
        btn4(1);
        idle4(n, saw);
        chk("restart_ones", 128'(cnt4(grid4, 4'd1)), 128'(2));
        chk("restart_empty", 128'(cnt4(grid4, 4'd0)), 128'(14));
        chk("restart_score", 128'(score4), 128'(0));
        chk("restart_flags", 128'({go4, mv4, saw}), 128'(0));

        btn5(0);
        idle5(n, saw);
        chk("n5_retry", 128'(n >= 3 && n < 200), 128'(1));
        e5 = '0;
        e5[(24-3)*5 +: 5] = 5'd1;
        e5[(24-9)*5 +: 5] = 5'd1;
        chk("n5_spawn_grid", 128'(grid5), 128'(e5));
        chk("n5_no_done", 128'(saw), 128'(0));
        @(negedge clk);
        dv5 = 1'b1; da5 = 5'd27; dd5 = 5'd7;
        @(negedge clk);
        dv5 = 1'b0;
        @(negedge clk);
        chk("n5_dbg_oob", 128'(grid5), 128'(e5));
        e5 = '0;
        e5[124 -: 5] = 5'd15;
        e5[119 -: 5] = 5'd15;
        set5(e5);
        btn5(0);
        n = 1;
        while (!md5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("n5_sat_done", 128'(n < 100), 128'(1));
        chk("n5_sat_score", 128'(score5), 128'(16'hFFFF));
        chk("n5_merge16", 128'(grid5[124 -: 5]), 128'(16));
        chk("n5_one_spawn", 128'(cnt5(grid5, 5'd0)), 128'(23));
        chk("n5_valid", 128'(mv5), 128'(1));

        btn4(0);
        chk("mid_busy", 128'(busy4), 128'(1));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_grid", 128'(grid4), 128'(0));
        chk("mid_rst_flags", 128'({score4, go4, busy4, md4, mv4}), 128'(0));
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
